// File: rtl/fetch_queue_if.sv
// Fetch-side handshake bundle: instruction-memory request/response, redirect and decode hand-off.
// The master modport is the fetch queue; the slave modport is the memory/pipeline environment.
interface fetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            ImemReqF;
  logic [XLEN-1:0] ImemAddrF;
  logic            ImemReadyF;
  logic            ImemValidF;
  logic [31:0]     ImemDataF;
  logic            RedirectE;
  logic [XLEN-1:0] RedirectPCE;
  logic            StallD;
  logic            ValidD;
  logic [31:0]     InstrD;
  logic [XLEN-1:0] PCD;
  logic [XLEN-1:0] PCPlus4D;
  logic [CW-1:0]   CountF;

  modport master (
    output ImemReqF, ImemAddrF, ValidD, InstrD, PCD, PCPlus4D, CountF,
    input  ImemReadyF, ImemValidF, ImemDataF, RedirectE, RedirectPCE, StallD
  );

  modport slave (
    input  ImemReqF, ImemAddrF, ValidD, InstrD, PCD, PCPlus4D, CountF,
    output ImemReadyF, ImemValidF, ImemDataF, RedirectE, RedirectPCE, StallD
  );
endinterface

// File: rtl/fetch_queue.sv
// In-order instruction fetch queue: reserves an entry per accepted request, fills on response,
// drains to decode, and discards in-flight responses after a redirect. Optional macro:
// FETCH_QUEUE_BYPASS_EN lets a response filling an empty head reach decode in the same cycle.
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.master fq
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = PW + 4;

  logic [XLEN-1:0] pc;
  logic [PW-1:0]   head;
  logic [CW-1:0]   count;
  logic [CW-1:0]   nfill;
  logic [DW-1:0]   drop;

  logic [XLEN-1:0] ent_pc    [DEPTH];
  logic [31:0]     ent_instr [DEPTH];

  logic            full;
  logic            accept;
  logic            resp_drop;
  logic            resp_fill;
  logic            head_filled;
  logic            valid_d;
  logic            pop;
  logic [CW-1:0]   unfilled;
  logic [PW-1:0]   tail_idx;
  logic [PW-1:0]   fill_idx;
  logic [DW-1:0]   drop_redirect;
  logic [31:0]     instr_head;

  assign full         = (count == CW'(DEPTH));
  assign fq.ImemReqF  = ~reset & ~full;
  assign fq.ImemAddrF = pc;
  assign accept       = fq.ImemReqF & fq.ImemReadyF;

  // Entries are ordered head..head+nfill-1 (filled) then up to head+count-1 (awaiting data).
  assign unfilled    = count - nfill;
  assign tail_idx    = head + count[PW-1:0];
  assign fill_idx    = head + nfill[PW-1:0];
  assign head_filled = (nfill != '0);

  assign resp_drop = fq.ImemValidF & (drop != '0);
  assign resp_fill = fq.ImemValidF & ~reset & ~fq.RedirectE & (drop == '0) & (unfilled != '0);

  // Every response still owed by memory is stale once we redirect; a response arriving now pays one off.
  assign drop_redirect = drop + DW'(unfilled) + DW'(accept) - DW'(fq.ImemValidF);

`ifdef FETCH_QUEUE_BYPASS_EN
  logic bypass;
  assign bypass     = resp_fill & ~head_filled;
  assign valid_d    = head_filled | bypass;
  assign instr_head = bypass ? fq.ImemDataF : ent_instr[head];
`else
  assign valid_d    = head_filled;
  assign instr_head = ent_instr[head];
`endif

  assign pop = valid_d & ~fq.StallD & ~fq.RedirectE;

  // Outputs read zero whenever no valid instruction is presented, so nothing stale leaks to decode.
  assign fq.ValidD   = valid_d;
  assign fq.InstrD   = valid_d ? instr_head : '0;
  assign fq.PCD      = valid_d ? ent_pc[head] : '0;
  assign fq.PCPlus4D = valid_d ? ent_pc[head] + XLEN'(4) : '0;
  assign fq.CountF   = count;

  // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= RESET_PC;
      head  <= '0;
      count <= '0;
      nfill <= '0;
      drop  <= '0;
    end else if (fq.RedirectE) begin
      pc    <= fq.RedirectPCE & ~XLEN'(3);
      head  <= '0;
      count <= '0;
      nfill <= '0;
      drop  <= drop_redirect;
    end else begin
      if (accept) pc <= pc + XLEN'(4);
      if (pop) head <= head + PW'(1);
      count <= count + CW'(accept) - CW'(pop);
      nfill <= nfill + CW'(resp_fill) - CW'(pop);
      if (resp_drop) drop <= drop - DW'(1);
    end
  end

  // NOTE: entry storage is not reset; occupancy is tracked by count/nfill alone.
  always_ff @(posedge clk) begin
    if (accept) ent_pc[tail_idx] <= pc;
    if (resp_fill) ent_instr[fill_idx] <= fq.ImemDataF;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a queue-level behavioural model.
`timescale 1ns/1ps
module tb_fetch_queue;
  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h100;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) f ();
  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk  (clk),
    .reset(reset),
    .fq   (f)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0] ^ 16'h5a3c, ~a[17:2]};
  endfunction

  // ---------------- stimulus / memory ----------------
  bit          s_reset = 1, s_rdy = 0, s_stall = 0, s_redir = 0, s_resp = 0;
  int          s_lat   = 1;
  logic [31:0] s_rpc   = '0;
  logic [31:0] mem_addr[$];
  int          mem_t[$];
  int          cyc = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    reset         = s_reset;
    f.ImemReadyF  = s_rdy;
    f.StallD      = s_stall;
    f.RedirectE   = s_redir;
    f.RedirectPCE = s_rpc;
    if (s_reset) begin
      mem_addr.delete();
      mem_t.delete();
    end
    if (!s_reset && s_resp && mem_addr.size() > 0 && (cyc - mem_t[0]) >= s_lat) begin
      f.ImemValidF = 1'b1;
      f.ImemDataF  = instr_of(mem_addr.pop_front());
      void'(mem_t.pop_front());
    end else begin
      f.ImemValidF = 1'b0;
      f.ImemDataF  = $urandom;
    end
    @(negedge clk);
    if (!reset && f.ImemReqF && f.ImemReadyF) begin
      mem_addr.push_back(f.ImemAddrF);
      mem_t.push_back(cyc);
    end
  endtask

  task automatic do_reset();
    s_reset = 1; s_redir = 0; s_rdy = 1; s_stall = 0; s_resp = 1; s_lat = 1;
    tick();
    tick();
    check("rst_CountF",    f.CountF,    0);
    check("rst_ImemReqF",  f.ImemReqF,  0);
    check("rst_ValidD",    f.ValidD,    0);
    check("rst_InstrD",    f.InstrD,    0);
    check("rst_PCD",       f.PCD,       0);
    check("rst_PCPlus4D",  f.PCPlus4D,  0);
    check("rst_ImemAddrF", f.ImemAddrF, 32'h100);
    s_reset = 0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!f.ValidD && n < 30) begin
      tick();
      n++;
    end
    check(name, f.ValidD, 1);
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  typedef struct {
    logic [31:0] pc;
    bit          filled;
    logic [31:0] instr;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc   = '0;
  logic [31:0] m_path = '0;
  int          m_drop = 0;
  bit          m_live = 0;

  always @(negedge clk) begin
    bit          e_valid, byp, e_req, acc, pop;
    logic [31:0] e_instr, e_pcd, e_pcp4;
    int          unf;
    ent_t        ne;
    byp = 0;
    if (BYP != 0)
      byp = !reset && !f.RedirectE && f.ImemValidF && m_drop == 0 && mq.size() > 0 && !mq[0].filled;
    e_valid = (mq.size() > 0 && mq[0].filled) || byp;
    e_instr = !e_valid ? 32'h0 : (byp ? f.ImemDataF : mq[0].instr);
    e_pcd   = e_valid ? mq[0].pc : 32'h0;
    e_pcp4  = e_valid ? mq[0].pc + 32'd4 : 32'h0;
    e_req   = !reset && mq.size() < DEPTH;
    if (m_live) begin
      check("m_ImemReqF",  f.ImemReqF,  e_req);
      check("m_ImemAddrF", f.ImemAddrF, m_pc);
      check("m_CountF",    f.CountF,    mq.size());
      check("m_ValidD",    f.ValidD,    e_valid);
      check("m_InstrD",    f.InstrD,    e_instr);
      check("m_PCD",       f.PCD,       e_pcd);
      check("m_PCPlus4D",  f.PCPlus4D,  e_pcp4);
    end
    acc = e_req && f.ImemReadyF;
    if (reset) begin
      mq.delete();
      m_pc   = RESET_PC;
      m_path = RESET_PC;
      m_drop = 0;
      m_live = 1;
    end else if (m_live) begin
      unf = 0;
      foreach (mq[i]) if (!mq[i].filled) unf++;
      if (f.RedirectE) begin
        m_drop = m_drop + unf + int'(acc) - int'(f.ImemValidF);
        mq.delete();
        m_pc   = f.RedirectPCE & ~32'h3;
        m_path = m_pc;
      end else begin
        pop = e_valid && !f.StallD;
        if (f.ImemValidF) begin
          if (m_drop > 0) m_drop--;
          else begin
            for (int k = 0; k < mq.size(); k++) begin
              if (!mq[k].filled) begin
                ne = mq[k];
                ne.filled = 1;
                ne.instr = f.ImemDataF;
                mq[k] = ne;
                break;
              end
            end
          end
        end
        if (pop) begin
          check("pop_path_pc", f.PCD, m_path);
          m_path = m_path + 32'd4;
          void'(mq.pop_front());
        end
        if (acc) begin
          ne.pc = m_pc;
          ne.filled = 0;
          ne.instr = '0;
          mq.push_back(ne);
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  // ---------------- directed scenarios then random traffic ----------------
  initial begin
    logic [31:0] acc_a[3];
    logic [31:0] pop_pc[3];
    logic [31:0] pop_p4[3];
    logic [31:0] pop_in[3];
    int          n_acc, n_pop, t_resp, t_valid;

    f.ImemReadyF = 0; f.ImemValidF = 0; f.ImemDataF = 0;
    f.RedirectE = 0; f.RedirectPCE = 0; f.StallD = 0;

    // Straight-line fetch from RESET_PC with single-cycle memory.
    do_reset();
    n_acc = 0; n_pop = 0; t_resp = -1; t_valid = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (f.ImemReqF && f.ImemReadyF && n_acc < 3) begin acc_a[n_acc] = f.ImemAddrF; n_acc++; end
      if (f.ImemValidF && t_resp < 0) t_resp = i;
      if (f.ValidD && t_valid < 0) t_valid = i;
      if (f.ValidD && !f.StallD && n_pop < 3) begin
        pop_pc[n_pop] = f.PCD; pop_p4[n_pop] = f.PCPlus4D; pop_in[n_pop] = f.InstrD; n_pop++;
      end
    end
    check("seq_acc_n", n_acc, 3);
    check("seq_pop_n", n_pop, 3);
    for (int k = 0; k < 3; k++) begin
      check("seq_addr",  acc_a[k],  32'h100 + 32'(4 * k));
      check("seq_pcd",   pop_pc[k], 32'h100 + 32'(4 * k));
      check("seq_pcp4",  pop_p4[k], 32'h104 + 32'(4 * k));
      check("seq_instr", pop_in[k], instr_of(32'h100 + 32'(4 * k)));
    end
    check("valid_latency", t_valid - t_resp, (BYP != 0) ? 0 : 1);

    // Stall decode: the queue fills to DEPTH and issue stops, then drains in order.
    do_reset();
    s_stall = 1;
    n_acc = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (f.ImemReqF && f.ImemReadyF) n_acc++;
    end
    check("stall_acc_n",  n_acc,      4);
    check("stall_count",  f.CountF,   4);
    check("stall_req",    f.ImemReqF, 0);
    check("stall_valid",  f.ValidD,   1);
    check("stall_pcd",    f.PCD,      32'h100);
    s_stall = 0;
    n_pop = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (f.ValidD && !f.StallD) begin
        check("drain_pc", f.PCD, 32'h100 + 32'(4 * n_pop));
        n_pop++;
      end
    end
    check("drain_enough", n_pop >= 8, 1);

    // Redirect with two requests outstanding; stale responses must vanish.
    do_reset();
    s_lat = 3;
    tick();
    tick();
    s_rdy = 0; s_redir = 1; s_rpc = 32'h2003;
    tick();
    check("redir_outstanding", f.CountF, 2);
    s_redir = 0; s_rdy = 1;
    tick();
    check("redir_addr",  f.ImemAddrF, 32'h2000);
    check("redir_count", f.CountF,    0);
    check("redir_valid", f.ValidD,    0);
    wait_valid("redir_first_valid");
    check("redir_pcd",   f.PCD,    32'h2000);
    check("redir_instr", f.InstrD, instr_of(32'h2000));

    // Redirect, acceptance and response all in the same cycle.
    do_reset();
    tick();
    s_redir = 1; s_rpc = 32'h3000;
    tick();
    check("same_cyc_accept", f.ImemReqF & f.ImemReadyF, 1);
    check("same_cyc_resp",   f.ImemValidF, 1);
    s_redir = 0;
    tick();
    check("same_cyc_count", f.CountF,    0);
    check("same_cyc_valid", f.ValidD,    0);
    check("same_cyc_instr", f.InstrD,    0);
    check("same_cyc_addr",  f.ImemAddrF, 32'h3000);
    wait_valid("same_cyc_first_valid");
    check("same_cyc_pcd", f.PCD, 32'h3000);

    // PC wrap at the top of the address space.
    do_reset();
    s_rdy = 0; s_redir = 1; s_rpc = 32'hFFFF_FFFC;
    tick();
    s_redir = 0; s_rdy = 1;
    tick();
    check("wrap_addr_top", f.ImemAddrF, 32'hFFFF_FFFC);
    tick();
    check("wrap_addr_zero", f.ImemAddrF, 32'h0);
    wait_valid("wrap_first_valid");
    check("wrap_pcd",  f.PCD,      32'hFFFF_FFFC);
    check("wrap_pcp4", f.PCPlus4D, 32'h0);

    // Randomized traffic, checked every cycle by the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      s_rdy   = ($urandom_range(3) != 0);
      s_stall = ($urandom_range(3) == 0);
      s_resp  = ($urandom_range(9) < 7);
      s_lat   = 1 + $urandom_range(2);
      s_redir = ($urandom_range(19) == 0);
      s_rpc   = $urandom;
      s_reset = ($urandom_range(299) == 0);
      tick();
    end
    s_reset = 0; s_redir = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter XLEN, default 32, address/PC width, SHALL be >= 32.
REQ-002 Parameter DEPTH, default 4, queue entries; SHALL be a power of 2 and >= 2.
REQ-003 Parameter RESET_PC, default 0, PC loaded on reset.
REQ-004 Ports SHALL be:
 - clk  in  1  sole clock, rising edge.
 - reset  in  1  synchronous, active-high.
 - ImemReqF  out  1  fetch request valid.
 - ImemAddrF  out  XLEN  fetch address.
 - ImemReadyF  in  1  request accepted this cycle when high with ImemReqF.
 - ImemValidF  in  1  in-order response, at least 1 cycle after acceptance.
 - ImemDataF  in  32  response instruction.
 - RedirectE  in  1  taken branch/jump (PCSrcE).
 - RedirectPCE  in  XLEN  redirect target.
 - StallD  in  1  decode cannot accept.
 - ValidD  out  1  InstrD/PCD/PCPlus4D hold a valid instruction.
 - InstrD  out  32  instruction to decode.
 - PCD  out  XLEN  PC of InstrD.
 - PCPlus4D  out  XLEN  PCD+4, modulo 2^XLEN.
 - CountF  out  clog2(DEPTH)+1  allocated entries (reserved plus filled).

Function
REQ-005 Fetch PC register SHALL drive ImemAddrF; RedirectPCE[1:0] is ignored and treated as 00.
REQ-006 ImemReqF SHALL be high iff not in reset and CountF < DEPTH.
REQ-007 On acceptance (ImemReqF & ImemReadyF), the block SHALL reserve the tail entry with the current PC, increment CountF, and advance PC by 4 with wrap-around at 2^XLEN.
REQ-008 Each non-discarded ImemValidF SHALL fill the oldest reserved, unfilled entry with ImemDataF.
REQ-009 ValidD SHALL be high iff the head entry is filled; InstrD/PCD/PCPlus4D SHALL come from the head entry.
REQ-010 Pop SHALL occur when ValidD & ~StallD & ~RedirectE: the head advances and CountF decrements; reserve and pop in the same cycle leave CountF unchanged.
REQ-011 With StallD high, the head entry and outputs SHALL hold; issue continues until CountF = DEPTH (full), then ImemReqF drops.
REQ-012 When RedirectE is high, on the next edge the block SHALL empty the queue (CountF=0, ValidD=0), load PC with RedirectPCE, and set a drop counter to the number of reserved-unfilled entries, including a request accepted in the same cycle.
REQ-013 While the drop counter is non-zero, each ImemValidF SHALL be discarded and decrement the counter; a response in the redirect cycle itself is counted before discard.
REQ-014 Issue SHALL resume the cycle after a redirect; new-path responses SHALL be filled only after the drop counter reaches 0.
REQ-015 Priority SHALL be reset > RedirectE > pop/fill/reserve.
REQ-016 Head/tail pointers SHALL wrap modulo DEPTH; full (CountF=DEPTH) and empty (CountF=0) SHALL be distinguished by CountF.

Reset
REQ-017 On the reset edge: PC=RESET_PC, CountF=0, drop counter=0, pointers=0, ValidD=0, ImemReqF=0, InstrD=0, PCD=0, PCPlus4D=0.
REQ-018 Reset mid-operation SHALL abandon all entries; responses arriving while reset is high SHALL be ignored. Responses arriving after reset for requests issued before reset are a system error, excluded from the contract.

Configuration
REQ-019 Macro FETCH_QUEUE_BYPASS_EN: when defined, a response filling an empty-queue head entry SHALL assert ValidD in the same cycle with InstrD=ImemDataF combinationally, and popping is allowed that cycle. When undefined, ValidD SHALL rise the cycle after the fill (registered outputs only).

Verification
REQ-020 Reset with RESET_PC=0x100, ImemReadyF=1, 1-cycle response latency, StallD=0 -> ImemAddrF 0x100, 0x104, 0x108; PCD sequence 0x100, 0x104, 0x108 with matching InstrD; PCPlus4D=PCD+4.
REQ-021 StallD held high for 10 cycles, DEPTH=4 -> exactly 4 acceptances, CountF=4, ImemReqF=0, PCD frozen; StallD released -> in-order drain, no lost or duplicated PC.
REQ-022 RedirectE=1 with RedirectPCE=0x2003 while 2 requests are outstanding -> next ImemAddrF=0x2000; the 2 stale responses are discarded; first ValidD shows PCD=0x2000.
REQ-023 Redirect, acceptance and response in the same cycle -> all counted and dropped; queue empty next cycle; no stale instruction on InstrD.
REQ-024 PC=0xFFFFFFFC (XLEN=32) -> next ImemAddrF=0x00000000 and PCPlus4D=0.
REQ-025 Empty queue, response at cycle T -> ValidD at T with FETCH_QUEUE_BYPASS_EN, T+1 without it.
